// File: rtl/jtgng_objdraw_flex_if.sv
// rtl/jtgng_objdraw_flex_if.sv - ROM fetch and line buffer write bus of the object drawer
interface jtgng_objdraw_flex_if #(
  parameter int PALW = 4,
  parameter int AW   = 17
);
  logic [AW-1:0]   rom_addr;
  logic            rom_cs;
  logic            rom_ok;
  logic [15:0]     rom_data;
  logic [8:0]      buf_addr;
  logic [PALW+3:0] buf_data;
  logic            buf_we;

  modport master (
    output rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    input  rom_ok, rom_data
  );

  modport slave (
    input  rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    output rom_ok, rom_data
  );
endinterface

// File: rtl/jtgng_objdraw_flex.sv
// rtl/jtgng_objdraw_flex.sv - object line drawer: zone check, row fetch, 4bpp pixel writes
module jtgng_objdraw_flex #(
  parameter int         SIZE    = 16,
  parameter int         CW      = 11,
  parameter int         PALW    = 4,
  parameter int         FLIP_EN = 1,
  parameter logic [3:0] TRANSP  = 4'hf
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic [7:0]            vrender,
  input  logic                  obj_start,
  input  logic [CW-1:0]         obj_code,
  input  logic [PALW-1:0]       obj_pal,
  input  logic [8:0]            obj_x,
  input  logic [7:0]            obj_y,
  input  logic                  obj_hflip,
  input  logic                  obj_vflip,
  output logic                  busy,
  jtgng_objdraw_flex_if.master  mem
);
  localparam int RW = $clog2(SIZE);
  localparam int WW = RW - 2;

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, DRAW} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   code;
  logic [PALW-1:0] pal;
  logic [8:0]      xcnt;
  logic [7:0]      ypos;
  logic            hf, vf;
  logic [RW-1:0]   row;
  logic [WW-1:0]   wc;
  logic [1:0]      pix;
  logic [15:0]     dat;
  logic [8:0]      buf_addr_r;
  logic [PALW+3:0] buf_data_r;
  logic            buf_we_r;

  logic [7:0]      dy;
  logic            in_zone;
  logic            last_word;
  logic [WW-1:0]   word;
  logic [1:0]      bit_idx;
  logic [3:0]      p0, p1, p2, p3;
  logic [3:0]      colour;

  assign dy        = vrender - ypos;
  assign in_zone   = dy < 8'(SIZE);
  assign last_word = wc == WW'(SIZE/4 - 1);
  assign word      = hf ? ~wc : wc;
  // Unflipped, the leftmost pixel lives in bit 3 of each plane
  assign bit_idx   = hf ? pix : ~pix;
  assign {p3, p2, p1, p0} = dat;
  assign colour    = {p0[bit_idx], p1[bit_idx], p2[bit_idx], p3[bit_idx]};

  assign busy         = state != IDLE;
  assign mem.rom_cs   = state == FETCH;
  assign mem.rom_addr = {code, row, word};
  assign mem.buf_addr = buf_addr_r;
  assign mem.buf_data = buf_data_r;
  assign mem.buf_we   = buf_we_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cen) begin
      case (state)
        IDLE:    if (obj_start) state_nxt = CHECK;
        CHECK:   state_nxt = in_zone ? FETCH : IDLE;
        FETCH:   if (mem.rom_ok) state_nxt = DRAW;
        DRAW:    if (pix == 2'd3) state_nxt = last_word ? IDLE : FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code       <= '0;
      pal        <= '0;
      xcnt       <= '0;
      ypos       <= '0;
      hf         <= 1'b0;
      vf         <= 1'b0;
      row        <= '0;
      wc         <= '0;
      pix        <= '0;
      dat        <= '0;
      buf_addr_r <= '0;
      buf_data_r <= '0;
      buf_we_r   <= 1'b0;
    end else if (cen) begin
      buf_we_r <= 1'b0;
      case (state)
        IDLE: begin
          if (obj_start) begin
            code <= obj_code;
            pal  <= obj_pal;
            xcnt <= obj_x;
            ypos <= obj_y;
            hf   <= (FLIP_EN != 0) && obj_hflip;
            vf   <= (FLIP_EN != 0) && obj_vflip;
          end
        end
        CHECK: begin
          row <= dy[RW-1:0] ^ {RW{vf}};
          wc  <= '0;
        end
        FETCH: begin
          if (mem.rom_ok) begin
            dat <= mem.rom_data;
            pix <= 2'd0;
          end
        end
        DRAW: begin
          buf_we_r   <= colour != TRANSP;
          buf_addr_r <= xcnt;
          buf_data_r <= {pal, colour};
          xcnt       <= xcnt + 9'd1;
          pix        <= pix + 2'd1;
          if (pix == 2'd3 && !last_word) wc <= wc + WW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtgng_objdraw_flex.sv
// tb/tb_jtgng_objdraw_flex.sv - randomized bench for jtgng_objdraw_flex (SIZE 16 and SIZE 32 instances)
module tb_jtgng_objdraw_flex;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [7:0]  vrender = '0;
  logic        start16 = 1'b0, start32 = 1'b0;
  logic [10:0] obj_code = '0;
  logic [5:0]  obj_pal = '0;
  logic [8:0]  obj_x = '0;
  logic [7:0]  obj_y = '0;
  logic        obj_hflip = 1'b0, obj_vflip = 1'b0;
  logic        busy16, busy32;
  logic        ok_drv = 1'b0;
  logic [31:0] salt = 32'h1234_5678;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 16;
  int stall    = 0;
  int wcnt     = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [18:0] a, input logic [31:0] s);
    logic [31:0] h;
    h = ({13'd0, a} ^ s) * 32'h9E37_79B1;
    return h[31:16] ^ h[15:0];
  endfunction

  jtgng_objdraw_flex_if #(.PALW(4), .AW(17)) m16();
  jtgng_objdraw_flex_if #(.PALW(6), .AW(19)) m32();

  assign m16.rom_ok   = ok_drv;
  assign m32.rom_ok   = ok_drv;
  assign m16.rom_data = rom_word({2'b00, m16.rom_addr}, salt);
  assign m32.rom_data = rom_word(m32.rom_addr, salt);

  jtgng_objdraw_flex #(.SIZE(16), .CW(11), .PALW(4)) dut16 (
    .clk(clk), .rst(rst), .cen(cen), .vrender(vrender), .obj_start(start16),
    .obj_code(obj_code), .obj_pal(obj_pal[3:0]), .obj_x(obj_x), .obj_y(obj_y),
    .obj_hflip(obj_hflip), .obj_vflip(obj_vflip), .busy(busy16), .mem(m16)
  );

  jtgng_objdraw_flex #(.SIZE(32), .CW(11), .PALW(6)) dut32 (
    .clk(clk), .rst(rst), .cen(cen), .vrender(vrender), .obj_start(start32),
    .obj_code(obj_code), .obj_pal(obj_pal), .obj_x(obj_x), .obj_y(obj_y),
    .obj_hflip(obj_hflip), .obj_vflip(obj_vflip), .busy(busy32), .mem(m32)
  );

  logic        cs_v, we_v, busy_v;
  logic [18:0] addr_v;
  logic [8:0]  baddr_v;
  logic [9:0]  bdata_v;

  always_comb begin
    if (sel == 32) begin
      cs_v = m32.rom_cs; we_v = m32.buf_we; busy_v = busy32;
      addr_v = m32.rom_addr; baddr_v = m32.buf_addr; bdata_v = m32.buf_data;
    end else begin
      cs_v = m16.rom_cs; we_v = m16.buf_we; busy_v = busy16;
      addr_v = {2'b00, m16.rom_addr}; baddr_v = m16.buf_addr; bdata_v = {2'b00, m16.buf_data};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        edge_cen = 1'b0;
  logic        cs_pre = 1'b0, ok_pre = 1'b0;

  // One clk period: outputs sampled 1 ns after the edge, new inputs driven right after
  task automatic step();
    cs_pre = cs_v;
    ok_pre = ok_drv;
    @(posedge clk);
    #1;
    edge_cen = cen;
    cen = ($urandom % 4) != 0;
    if (!cs_v) wcnt = 0;
    else if (edge_cen && cs_pre) wcnt++;
    ok_drv = cs_v ? (wcnt >= stall) : 1'($urandom % 2);
  endtask

  task automatic set_start(input int size, input logic v);
    if (size == 32) start32 = v;
    else            start16 = v;
  endtask

  task automatic run_obj(input int size, input logic [10:0] code, input logic [5:0] pal,
                         input logic [8:0] x, input logic [7:0] y, input logic [7:0] vr,
                         input logic hf, input logic vf, input int stl, input bit do_rst);
    int   q_fetch[$];
    int   q_addr[$];
    int   q_data[$];
    int   n, row, s, a, b, exp_dur, exp_fetch, dur, steps, n_fetch, rst_at;
    logic [7:0]  dyv;
    logic [15:0] d;
    logic [3:0]  col;
    logic [5:0]  pal_eff;
    bit   accepted, done, in_zone;

    n       = size / 4;
    pal_eff = (size == 32) ? pal : {2'b00, pal[3:0]};
    dyv     = vr - y;
    in_zone = int'(dyv) < size;
    exp_dur = in_zone ? 2 + n * (5 + stl) : 2;
    exp_fetch = in_zone ? n : 0;
    rst_at  = do_rst ? 5 + stl : -1;
    if (in_zone) begin
      row = vf ? size - 1 - int'(dyv) : int'(dyv);
      for (int w = 0; w < n; w++)
        q_fetch.push_back(int'(code) * size * n + row * n + (hf ? n - 1 - w : w));
      for (int k = 0; k < size; k++) begin
        if (do_rst && k >= 2) break;
        s   = hf ? size - 1 - k : k;
        a   = int'(code) * size * n + row * n + s / 4;
        d   = rom_word(19'(a), salt);
        b   = 3 - s % 4;
        col = {d[b], d[4+b], d[8+b], d[12+b]};
        if (col != 4'hf) begin
          q_addr.push_back((int'(x) + k) % 512);
          q_data.push_back(int'(pal_eff) * 16 + int'(col));
        end
      end
    end

    sel = size; stall = stl;
    vrender = vr; obj_code = code; obj_pal = pal; obj_x = x; obj_y = y;
    obj_hflip = hf; obj_vflip = vf;
    set_start(size, 1'b1);
    accepted = 0; done = 0; dur = 0; steps = 0; n_fetch = 0;

    while (!done && steps < 3000) begin
      step();
      steps++;
      if (!accepted) begin
        if (edge_cen) begin
          accepted = 1;
          dur = 1;
          check("busy_on_accept", 32'(busy_v), 32'd1);
        end
      end else begin
        if (edge_cen) dur++;
        if (edge_cen && cs_pre && ok_pre) begin
          n_fetch++;
          if (q_fetch.size() > 0) void'(q_fetch.pop_front());
        end
        if (cs_v) begin
          if (q_fetch.size() > 0) check("rom_addr", 32'(addr_v), 32'(q_fetch[0]));
          else                    check("rom_cs_unexpected", 32'(cs_v), 32'd0);
        end
        if (edge_cen && we_v) begin
          if (q_addr.size() == 0) check("extra_write", 32'd1, 32'd0);
          else begin
            check("buf_addr", 32'(baddr_v), 32'(q_addr.pop_front()));
            check("buf_data", 32'(bdata_v), 32'(q_data.pop_front()));
          end
        end
        if (edge_cen && !busy_v) done = 1;
        if (edge_cen && dur == rst_at) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          check("rst_busy", 32'(busy_v), 32'd0);
          check("rst_rom_cs", 32'(cs_v), 32'd0);
          check("rst_buf_we", 32'(we_v), 32'd0);
          done = 1;
        end
      end
      set_start(size, busy_v & 1'($urandom % 2));
      if (!accepted) set_start(size, 1'b1);
    end
    set_start(size, 1'b0);
    check("finished_in_budget", 32'(done), 32'd1);
    check("writes_left", 32'(q_addr.size()), 32'd0);
    if (!do_rst) begin
      check("duration", 32'(dur), 32'(exp_dur));
      check("fetch_count", 32'(n_fetch), 32'(exp_fetch));
    end
  endtask

  initial begin
    salt = $urandom;
    repeat (3) step();
    sel = 16;
    check("rst16_busy", 32'(busy_v), 32'd0);
    check("rst16_cs", 32'(cs_v), 32'd0);
    check("rst16_we", 32'(we_v), 32'd0);
    check("rst16_addr", 32'(addr_v), 32'd0);
    check("rst16_baddr", 32'(baddr_v), 32'd0);
    check("rst16_bdata", 32'(bdata_v), 32'd0);
    sel = 32;
    check("rst32_busy", 32'(busy_v), 32'd0);
    check("rst32_cs", 32'(cs_v), 32'd0);
    check("rst32_addr", 32'(addr_v), 32'd0);
    rst = 1'b0;
    step();

    run_obj(16, 11'h123, 6'h5, 9'h010, 8'h3E, 8'h40, 1'b0, 1'b0, 0, 0);
    run_obj(16, 11'h123, 6'h5, 9'h010, 8'h50, 8'h40, 1'b0, 1'b0, 0, 0);
    run_obj(16, 11'h123, 6'h5, 9'h010, 8'h3E, 8'h40, 1'b1, 1'b1, 0, 0);
    run_obj(16, 11'h123, 6'h9, 9'h1FC, 8'h3E, 8'h40, 1'b0, 1'b0, 3, 0);
    run_obj(32, 11'h2A5, 6'h2B, 9'h080, 8'h30, 8'h40, 1'b0, 1'b1, 1, 0);
    run_obj(16, 11'h0F0, 6'h3, 9'h020, 8'h31, 8'h40, 1'b0, 1'b0, 0, 0);
    run_obj(16, 11'h0F0, 6'h3, 9'h020, 8'h30, 8'h40, 1'b0, 1'b0, 0, 0);
    run_obj(32, 11'h0F1, 6'h3F, 9'h1F0, 8'h21, 8'h40, 1'b1, 1'b0, 0, 0);
    run_obj(32, 11'h0F1, 6'h3F, 9'h1F0, 8'h20, 8'h40, 1'b1, 1'b0, 0, 0);
    run_obj(16, 11'h456, 6'h7, 9'h030, 8'h3E, 8'h40, 1'b0, 1'b0, 0, 1);
    run_obj(16, 11'h123, 6'h5, 9'h010, 8'h3E, 8'h40, 1'b0, 1'b0, 0, 0);
    run_obj(32, 11'h321, 6'h11, 9'h040, 8'h10, 8'h20, 1'b1, 1'b1, 2, 1);

    for (int i = 0; i < 24; i++) begin
      int       sz;
      logic [7:0] vr;
      sz = ($urandom % 2) ? 32 : 16;
      vr = 8'($urandom);
      run_obj(sz, 11'($urandom), 6'($urandom), 9'($urandom), vr - 8'($urandom_range(0, 40)), vr,
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jtgng_objdraw_flex.md
# jtgng_objdraw_flex

Parametrised object line drawer for the next generation of 8-bit Capcom-style cores. It accepts one object descriptor at a time from the per-line object scanner and checks its vertical zone. It then fetches the object's row from SDRAM over a cs/ok handshake and writes decoded 4bpp pixels, with palette bits attached, into the external line buffer. Unlike the fixed 16×16 no-flip drawer, it supports 16 or 32 pixel objects, H/V flip, a configurable palette width and ROM stalls.

## Interface
Parameters:
- SIZE, 16: object width and height in pixels; legal values 16, 32.
- CW, 11: object code width.
- PALW, 4: palette field width (1..6).
- FLIP_EN, 1: 0 forces hflip/vflip inputs to be ignored.
- TRANSP, 4'hf: colour index that is never written.
- Derived: RW = log2(SIZE), WW = RW-2 (words per row index), AW = CW+RW+WW.

Ports:
- clk  in  1  system clock (24 MHz).
- rst  in  1  reset; synchronous to clk, active-high.
- cen  in  1  pixel clock enable; every state change and output update happens only on clk edges with cen=1.
- vrender  in  8  line being drawn.
- obj_start  in  1  descriptor valid; accepted only when busy=0.
- obj_code  in  CW  object code.
- obj_pal  in  PALW  palette.
- obj_x  in  9  left X.
- obj_y  in  8  top Y.
- obj_hflip, obj_vflip  in  1  flip flags.
- busy  out  1  high from acceptance until the last pixel is written.
- rom_addr  out  AW  {code, row, word}.
- rom_cs  out  1  fetch request.
- rom_ok  in  1  rom_data valid for the current rom_addr.
- rom_data  in  16  4 pixels × 4 planes, layout {p3[3:0],p2[3:0],p1[3:0],p0[3:0]}.
- buf_addr  out  9  line buffer X.
- buf_data  out  PALW+4  {pal, colour}.
- buf_we  out  1  write strobe, one clk wide, only on cen cycles.

## Operation
- States: IDLE, CHECK, FETCH, DRAW.
- IDLE:
  - busy=0.
  - When obj_start=1 on a cen cycle, latch all obj_* inputs and go to CHECK.
  - A start arriving while busy is ignored.
- CHECK:
  - Compute dy = vrender - obj_y (8-bit, mod 256).
  - If dy ≥ SIZE, return to IDLE without any fetch.
  - Otherwise row = dy[RW-1:0], inverted when vflip is set and FLIP_EN=1.
  - Set the word counter wc = 0 and the X counter to obj_x, then go to FETCH.
- FETCH:
  - rom_cs=1, rom_addr = {code, row, hf ? ~wc : wc}.
  - On cen with rom_ok=1, latch rom_data, drop rom_cs and go to DRAW.
  - rom_ok is ignored on cycles where rom_cs=0.
- DRAW: four cen cycles, pixel index i = 0..3.
  - Colour = {p0[3-i], p1[3-i], p2[3-i], p3[3-i]} when not flipped, or bit i of each plane when hflip is set.
  - buf_we=1 unless the colour equals TRANSP.
  - buf_addr = X counter, which then increments mod 512. Wrap-around is allowed; nothing is clipped.
  - After i=3: if wc = SIZE/4-1, go to IDLE, otherwise increment wc and go to FETCH.
- Reset values:
  - State IDLE.
  - busy=0, rom_cs=0, buf_we=0.
  - rom_addr=0, buf_addr=0, buf_data=0.
- Reset asserted mid-fetch or mid-draw aborts immediately. No write occurs on the reset cycle.

## Timing
- Acceptance (start on a cen cycle) to CHECK: 1 cen.
- CHECK to rom_cs high: 1 cen.
- With rom_ok already high, the first buf_we comes on the cen after the ok cycle.
- Zero-stall object duration: 1 + 1 + SIZE/4 × (1 + 4) cen. SIZE=16 gives 22 cen; SIZE=32 gives 42 cen.
- An out-of-zone object takes 2 cen from start to busy=0.
- Each rom_ok wait adds one cen per stalled cycle. rom_addr stays stable while rom_cs=1.
- busy falls on the same cen edge that performs the last pixel's write.
- With cen=0, all registers hold, and buf_we and rom_cs keep their values but must not be counted as new events.

## Test plan
- Visible, no flip:
  - Stimulus: SIZE=16, vrender=0x40, obj_y=0x3E, code=0x123, x=0x010, rom_ok tied 1.
  - Required: rom_addr = {0x123, row 2, word 0..3}; 16 pixels written at buf_addr 0x010..0x01F, skipping TRANSP; busy lasts 22 cen.
- Out of zone:
  - Stimulus: obj_y=0x50, vrender=0x40.
  - Required: rom_cs never asserted; busy high for exactly 2 cen.
- Flips:
  - Stimulus: same object as the first scenario with hflip=vflip=1.
  - Required: row = 13; word order 3,2,1,0; pixel order within each word mirrored; buf_addr still 0x010..0x01F.
- Wrap and stall:
  - Stimulus: x=0x1FC, rom_ok held low 3 cen on each fetch.
  - Required: writes at 0x1FC..0x1FF then 0x000..0x00B; total 22 + 12 cen; rom_addr constant during each stall.
- SIZE=32, PALW=6:
  - Required: 8 fetches, 32 pixels, buf_data[9:4] equals obj_pal.
- Reset at DRAW pixel 2:
  - Required: next cycle busy=0, rom_cs=0, buf_we=0; the next obj_start is accepted normally.
